// File: rtl/battle_turn_ctrl.sv
// battle_turn_ctrl
// Turn sequencer and health ledger for the battle screen. It issues attack
// requests to the damage-roll block (player turn -> attack on the enemy,
// enemy turn -> attack on the player), applies the returned damage with
// saturation at zero and declares a winner. Enemy moves come from an
// internal 8-bit LFSR.
//
// Ports
//   clk, rst_n            : clock, synchronous active-low reset
//   start                 : begin a battle (IDLE / OVER only)
//   p_move_valid, p_move  : player move offer; p_move_ready high in P_WAIT
//   attack_e, att_e_en    : attack code and request strobe towards enemy
//   attack_p, att_p_en    : attack code and request strobe towards player
//   HP_e, HP_e_en         : damage response for the enemy
//   HP_p, HP_p_en         : damage response for the player
//   hp_player, hp_enemy   : health values
//   turn                  : 0 player's turn, 1 enemy's turn
//   last_dmg, last_miss   : most recent resolved damage / zero-damage flag
//   resp_err              : sticky response-timeout flag
//   battle_over, winner   : end of battle, 0 player won / 1 enemy won
module battle_turn_ctrl #(
  parameter logic [7:0] MAX_HP       = 8'd100,
  parameter int         WAIT_CYCLES  = 16,
  parameter int         RESP_TIMEOUT = 4,
  parameter logic [7:0] LFSR_SEED    = 8'hA5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       p_move_valid,
  input  logic [1:0] p_move,
  output logic       p_move_ready,
  output logic [1:0] attack_e,
  output logic       att_e_en,
  output logic [1:0] attack_p,
  output logic       att_p_en,
  input  logic [7:0] HP_e,
  input  logic       HP_e_en,
  input  logic [7:0] HP_p,
  input  logic       HP_p_en,
  output logic [7:0] hp_player,
  output logic [7:0] hp_enemy,
  output logic       turn,
  output logic [7:0] last_dmg,
  output logic       last_miss,
  output logic       resp_err,
  output logic       battle_over,
  output logic       winner
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_P_WAIT  = 3'd1,
    S_P_ISSUE = 3'd2,
    S_P_RESP  = 3'd3,
    S_GAP     = 3'd4,
    S_E_ISSUE = 3'd5,
    S_E_RESP  = 3'd6,
    S_OVER    = 3'd7
  } state_t;

  // An all-zero seed would lock the LFSR, so it is replaced by 1.
  localparam logic [7:0]  SEED     = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;
  localparam logic [15:0] GAP_LAST = 16'(WAIT_CYCLES - 1);
  localparam logic [7:0]  TO_LAST  = 8'(RESP_TIMEOUT - 1);

  // Saturating subtraction: damage never wraps health below zero.
  function automatic logic [7:0] sat_sub(input logic [7:0] hp, input logic [7:0] dmg);
    logic [7:0] res;
    if (dmg >= hp) begin
      res = 8'd0;
    end else begin
      res = hp - dmg;
    end
    return res;
  endfunction

  state_t      state_q;
  logic [7:0]  lfsr_q;
  logic [7:0]  lfsr_d;
  logic [15:0] gap_cnt_q;
  logic [7:0]  resp_cnt_q;
  logic [7:0]  hp_e_hit_d;
  logic [7:0]  hp_p_hit_d;

  logic       p_move_ready_q;
  logic [1:0] attack_e_q;
  logic       att_e_en_q;
  logic [1:0] attack_p_q;
  logic       att_p_en_q;
  logic [7:0] hp_player_q;
  logic [7:0] hp_enemy_q;
  logic       turn_q;
  logic [7:0] last_dmg_q;
  logic       last_miss_q;
  logic       resp_err_q;
  logic       battle_over_q;
  logic       winner_q;

  // Fibonacci LFSR, taps 8,6,5,4, shifting towards the MSB.
  assign lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

  assign hp_e_hit_d = sat_sub(hp_enemy_q, HP_e);
  assign hp_p_hit_d = sat_sub(hp_player_q, HP_p);

  // Turn FSM with all registered outputs and the free-running LFSR.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      lfsr_q         <= SEED;
      gap_cnt_q      <= 16'd0;
      resp_cnt_q     <= 8'd0;
      p_move_ready_q <= 1'b0;
      attack_e_q     <= 2'd0;
      att_e_en_q     <= 1'b0;
      attack_p_q     <= 2'd0;
      att_p_en_q     <= 1'b0;
      hp_player_q    <= MAX_HP;
      hp_enemy_q     <= MAX_HP;
      turn_q         <= 1'b0;
      last_dmg_q     <= 8'd0;
      last_miss_q    <= 1'b0;
      resp_err_q     <= 1'b0;
      battle_over_q  <= 1'b0;
      winner_q       <= 1'b0;
    end else begin
      lfsr_q     <= lfsr_d;
      // Strobes are single-cycle; only the ISSUE entry raises them.
      att_e_en_q <= 1'b0;
      att_p_en_q <= 1'b0;
      case (state_q)
        S_IDLE, S_OVER: begin
          if (start) begin
            hp_player_q    <= MAX_HP;
            hp_enemy_q     <= MAX_HP;
            battle_over_q  <= 1'b0;
            resp_err_q     <= 1'b0;
            last_miss_q    <= 1'b0;
            last_dmg_q     <= 8'd0;
            turn_q         <= 1'b0;
            p_move_ready_q <= 1'b1;
            state_q        <= S_P_WAIT;
          end
        end
        S_P_WAIT: begin
          if (p_move_valid && p_move_ready_q) begin
            attack_e_q     <= p_move;
            att_e_en_q     <= 1'b1;
            p_move_ready_q <= 1'b0;
            state_q        <= S_P_ISSUE;
          end
        end
        S_P_ISSUE: begin
          // A response arriving during ISSUE is deliberately not looked at.
          resp_cnt_q <= 8'd0;
          state_q    <= S_P_RESP;
        end
        S_P_RESP: begin
          if (HP_e_en) begin
            hp_enemy_q  <= hp_e_hit_d;
            last_dmg_q  <= HP_e;
            last_miss_q <= (HP_e == 8'd0);
            gap_cnt_q   <= 16'd0;
            if (hp_e_hit_d == 8'd0) begin
              battle_over_q <= 1'b1;
              winner_q      <= 1'b0;
              state_q       <= S_OVER;
            end else begin
              state_q <= S_GAP;
            end
          end else if (resp_cnt_q == TO_LAST) begin
            last_dmg_q  <= 8'd0;
            last_miss_q <= 1'b1;
            resp_err_q  <= 1'b1;
            gap_cnt_q   <= 16'd0;
            state_q     <= S_GAP;
          end else begin
            resp_cnt_q <= resp_cnt_q + 8'd1;
          end
        end
        S_GAP: begin
          if (gap_cnt_q == GAP_LAST) begin
            // turn still names the side that just attacked.
            if (!turn_q) begin
              turn_q     <= 1'b1;
              attack_p_q <= lfsr_q[1:0];
              att_p_en_q <= 1'b1;
              state_q    <= S_E_ISSUE;
            end else begin
              turn_q         <= 1'b0;
              p_move_ready_q <= 1'b1;
              state_q        <= S_P_WAIT;
            end
          end else begin
            gap_cnt_q <= gap_cnt_q + 16'd1;
          end
        end
        S_E_ISSUE: begin
          resp_cnt_q <= 8'd0;
          state_q    <= S_E_RESP;
        end
        S_E_RESP: begin
          if (HP_p_en) begin
            hp_player_q <= hp_p_hit_d;
            last_dmg_q  <= HP_p;
            last_miss_q <= (HP_p == 8'd0);
            gap_cnt_q   <= 16'd0;
            if (hp_p_hit_d == 8'd0) begin
              battle_over_q <= 1'b1;
              winner_q      <= 1'b1;
              state_q       <= S_OVER;
            end else begin
              state_q <= S_GAP;
            end
          end else if (resp_cnt_q == TO_LAST) begin
            last_dmg_q  <= 8'd0;
            last_miss_q <= 1'b1;
            resp_err_q  <= 1'b1;
            gap_cnt_q   <= 16'd0;
            state_q     <= S_GAP;
          end else begin
            resp_cnt_q <= resp_cnt_q + 8'd1;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign p_move_ready = p_move_ready_q;
  assign attack_e     = attack_e_q;
  assign att_e_en     = att_e_en_q;
  assign attack_p     = attack_p_q;
  assign att_p_en     = att_p_en_q;
  assign hp_player    = hp_player_q;
  assign hp_enemy     = hp_enemy_q;
  assign turn         = turn_q;
  assign last_dmg     = last_dmg_q;
  assign last_miss    = last_miss_q;
  assign resp_err     = resp_err_q;
  assign battle_over  = battle_over_q;
  assign winner       = winner_q;

endmodule
